// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci table writer and reader.
package fib_pkg;

  // Largest index whose fib value fits a 16-bit word (fib(23) = 46368).
  localparam int unsigned FIB_MAX_INDEX  = 23;
  localparam int unsigned FIB_BASE_VALUE = 1;

  typedef enum logic [1:0] {
    StatHit  = 2'd0,
    StatMiss = 2'd1,
    StatOvf  = 2'd2
  } fib_status_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } fib_state_e;

endpackage

// File: rtl/fib_valid_tracker.sv
// Tracks the highest index of the Fibonacci table that has been filled
// contiguously from the base cases, by snooping port-A writes.
module fib_valid_tracker #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_INDEX = fib_pkg::FIB_MAX_INDEX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snoop_wren,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] valid_top
);

  logic extend;

  // Only the write immediately above the current top extends the valid range.
  always_comb begin
    extend = snoop_wren && (snoop_addr == valid_top + ADDR_W'(1)) &&
             (valid_top < ADDR_W'(MAX_INDEX));
  end

  // Indices 0 and 1 are always valid; invalidate beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset || invalidate) begin
      valid_top <= ADDR_W'(1);
    end else if (extend) begin
      valid_top <= valid_top + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fib_table_reader.sv
// Serves fib(N) lookups from the FBC table over RAM port B. Base cases,
// overflowing indices and not-yet-written entries are answered directly.
module fib_table_reader
  import fib_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned MAX_INDEX   = FIB_MAX_INDEX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_index,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              snoop_wren,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] valid_top
);

  fib_state_e state;
  logic [1:0] wait_cnt;

  fib_valid_tracker #(
    .ADDR_W    (ADDR_W),
    .MAX_INDEX (MAX_INDEX)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .snoop_wren (snoop_wren),
    .snoop_addr (snoop_addr),
    .invalidate (invalidate),
    .valid_top  (valid_top)
  );

  // Only input-facing output that is decoded rather than registered.
  always_comb begin
    req_ready = (state == StIdle);
  end

  // Request FSM with registered response and RAM strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      wait_cnt    <= 2'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_status  <= StatHit;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            if (req_index > ADDR_W'(MAX_INDEX)) begin
              rsp_valid  <= 1'b1;
              rsp_data   <= '0;
              rsp_status <= StatOvf;
              state      <= StResp;
            end else if (req_index <= ADDR_W'(1)) begin
              rsp_valid  <= 1'b1;
              rsp_data   <= DATA_W'(FIB_BASE_VALUE);
              rsp_status <= StatHit;
              state      <= StResp;
            end else if (req_index <= valid_top) begin
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= req_index;
              state       <= StRead;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_data   <= '0;
              rsp_status <= StatMiss;
              state      <= StResp;
            end
          end
        end
        StRead: begin
          ram_rd_en <= 1'b0;
          wait_cnt  <= 2'd0;
          state     <= StWait;
        end
        StWait: begin
          // Data lands RAM_LATENCY cycles after the strobe; capture on the last.
          if (wait_cnt == 2'(RAM_LATENCY - 1)) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= ram_rd_data;
            rsp_status <= StatHit;
            state      <= StResp;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_table_reader.sv
// Directed self-checking bench for fib_table_reader.
module tb_fib_table_reader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_index;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              snoop_wren;
  logic [ADDR_W-1:0] snoop_addr;
  logic              invalidate;
  logic [ADDR_W-1:0] valid_top;

  logic [DATA_W-1:0] mem [64];
  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;

  fib_table_reader dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .snoop_wren  (snoop_wren),
    .snoop_addr  (snoop_addr),
    .invalidate  (invalidate),
    .valid_top   (valid_top)
  );

  always #5 clk = ~clk;

  // Port-B model with one cycle of read latency, plus a strobe counter.
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rd_data <= mem[ram_rd_addr[5:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle once the block is ready; returns in T+1.
  task automatic accept(input int idx);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_index = ADDR_W'(idx);
    tick();
    req_valid = 1'b0;
  endtask

  // Called in T+1; checks latency and payload, then completes the handshake.
  task automatic expect_rsp(input string tag, input int st, input int data, input int lat);
    int c = 1;
    while (!rsp_valid && c < 20) begin
      tick();
      c++;
    end
    check_eq({tag, "_lat"}, 32'(c), 32'(lat));
    check_eq({tag, "_status"}, 32'(rsp_status), 32'(st));
    check_eq({tag, "_data"}, 32'(rsp_data), 32'(data));
    tick();
    check_eq({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic snoop(input int addr);
    snoop_wren = 1'b1;
    snoop_addr = ADDR_W'(addr);
    tick();
    snoop_wren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd_base;
    logic stable;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 16'd1;
    mem[1] = 16'd1;
    for (int i = 2; i < 24; i++) mem[i] = mem[i-1] + mem[i-2];

    reset = 1'b1; req_valid = 1'b0; req_index = '0; rsp_ready = 1'b1;
    snoop_wren = 1'b0; snoop_addr = '0; invalidate = 1'b0; ram_rd_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_status", 32'(rsp_status), 32'd0);
    check_eq("rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
    check_eq("rst_ram_rd_addr", 32'(ram_rd_addr), 32'd0);
    check_eq("rst_valid_top", 32'(valid_top), 32'd1);

    // Base cases
    accept(0); expect_rsp("base0", 0, 1, 1);
    accept(1); expect_rsp("base1", 0, 1, 1);
    check_eq("base_no_ram", 32'(rd_cnt), 32'd0);

    // Fill 2..10, read index 10 through the RAM
    for (int k = 2; k <= 10; k++) snoop(k);
    check_eq("fill_top", 32'(valid_top), 32'd10);
    accept(10);
    check_eq("hit10_rd_en", 32'(ram_rd_en), 32'd1);
    check_eq("hit10_rd_addr", 32'(ram_rd_addr), 32'd10);
    expect_rsp("hit10", 0, 89, 3);
    check_eq("hit10_one_read", 32'(rd_cnt), 32'd1);

    // Miss above valid_top, overflow above MAX_INDEX
    accept(11); expect_rsp("miss11", 1, 0, 1);
    accept(24); expect_rsp("ovf24", 2, 0, 1);
    check_eq("miss_ovf_no_ram", 32'(rd_cnt), 32'd1);

    // Contiguity
    invalidate = 1'b1; tick(); invalidate = 1'b0;
    check_eq("inv_top", 32'(valid_top), 32'd1);
    snoop(2); snoop(3);
    snoop(5);
    check_eq("gap_ignored", 32'(valid_top), 32'd3);
    snoop(4);
    check_eq("gap_filled", 32'(valid_top), 32'd4);

    // Response held under backpressure while invalidate pulses
    rsp_ready = 1'b0;
    accept(4);
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      invalidate = (i == 0);
      if (!(rsp_valid === 1'b1 && rsp_data === 16'd5 && rsp_status === 2'd0)) stable = 1'b0;
      tick();
    end
    invalidate = 1'b0;
    check_eq("hold_stable", 32'(stable), 32'd1);
    check_eq("hold_still_valid", 32'(rsp_valid), 32'd1);
    check_eq("hold_inv_top", 32'(valid_top), 32'd1);
    rsp_ready = 1'b1;
    tick();
    check_eq("hold_released", 32'(rsp_valid), 32'd0);
    accept(2); expect_rsp("miss2_after_inv", 1, 0, 1);

    // Write and request of the same index in one cycle: still a miss
    snoop_wren = 1'b1; snoop_addr = ADDR_W'(2);
    req_valid = 1'b1; req_index = ADDR_W'(2);
    tick();
    snoop_wren = 1'b0; req_valid = 1'b0;
    expect_rsp("same_cycle_miss", 1, 0, 1);
    accept(2); expect_rsp("hit2", 0, 2, 3);

    // Invalidate beats a simultaneous contiguous write
    invalidate = 1'b1; snoop_wren = 1'b1; snoop_addr = ADDR_W'(3);
    tick();
    invalidate = 1'b0; snoop_wren = 1'b0;
    check_eq("inv_wins", 32'(valid_top), 32'd1);

    // Saturation at MAX_INDEX
    for (int k = 2; k <= 24; k++) snoop(k);
    check_eq("sat_top", 32'(valid_top), 32'd23);
    accept(23); expect_rsp("hit23", 0, 46368, 3);

    // Reset while waiting on the RAM drops the transaction
    accept(5);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_valid_top", 32'(valid_top), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0) stable = 1'b0;
      tick();
    end
    check_eq("midrst_no_rsp", 32'(stable), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
